// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel stream in / 3x3 window out bundle for sobel_window_gen
interface sobel_window_gen_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        sof;
  logic [7:0]  p00, p01, p02;
  logic [7:0]  p10, p11, p12;
  logic [7:0]  p20, p21, p22;
  logic        win_valid;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
    input  win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p00, p01, p02, p10, p11, p12, p20, p21, p22,
    output win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster pixel stream to 3x3 neighbourhood with two line buffers
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic            clk,
  input  logic            rst,
  sobel_window_gen_if.slave s
);
  localparam int AW = $clog2(IMG_WIDTH);

  logic [15:0] row, col;
  logic [15:0] cur_row, cur_col;
  logic        last_col, last_row, last_pix, full_win;
  logic [7:0]  rd1, rd2;
  logic [AW-1:0] idx;

  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];

  logic [7:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic       win_valid_q, frame_done_q;
  logic [15:0] win_row_q, win_col_q;

  // sof overrides the counters so the pixel lands at (0,0) this same cycle
  always_comb begin
    cur_row  = s.sof ? 16'd0 : row;
    cur_col  = s.sof ? 16'd0 : col;
    last_col = (cur_col == 16'(IMG_WIDTH - 1));
    last_row = (cur_row == 16'(IMG_HEIGHT - 1));
    last_pix = !s.sof && last_col && last_row;
    full_win = (cur_row >= 16'd2) && (cur_col >= 16'd2);
    idx      = cur_col[AW-1:0];
    rd1      = lb1[idx];
    rd2      = lb2[idx];
  end

  // Line buffers are not reset; row>=2 gating hides whatever they held before
  always_ff @(posedge clk) begin
    if (!rst && s.pix_valid) begin
      lb1[idx] <= s.pix_in;
      lb2[idx] <= rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      w00 <= '0; w01 <= '0; w02 <= '0;
      w10 <= '0; w11 <= '0; w12 <= '0;
      w20 <= '0; w21 <= '0; w22 <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (s.pix_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? 16'd0 : cur_row + 16'd1;
        end else begin
          col <= cur_col + 16'd1;
          row <= cur_row;
        end
        w00 <= w01; w01 <= w02; w02 <= rd2;
        w10 <= w11; w11 <= w12; w12 <= rd1;
        w20 <= w21; w21 <= w22; w22 <= s.pix_in;
        win_valid_q  <= full_win;
        frame_done_q <= last_pix;
        if (full_win) begin
          win_row_q <= cur_row - 16'd1;
          win_col_q <= cur_col - 16'd1;
        end
      end
    end
  end

  assign s.p00 = w00;
  assign s.p01 = w01;
  assign s.p02 = w02;
  assign s.p10 = w10;
  assign s.p11 = w11;
  assign s.p12 = w12;
  assign s.p20 = w20;
  assign s.p21 = w21;
  assign s.p22 = w22;
  assign s.win_valid  = win_valid_q;
  assign s.win_row    = win_row_q;
  assign s.win_col    = win_col_q;
  assign s.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen (5x4 frames plus 8x8 edge image)
module tb_sobel_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  typedef struct packed {
    logic [71:0] win;
    logic [15:0] row;
    logic [15:0] col;
    logic        fd;
  } exp_t;

  typedef struct packed {
    logic [15:0] edge_val;
    logic [15:0] col;
  } exp8_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_gen_if bus ();
  sobel_window_gen_if bus8 ();

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (.clk(clk), .rst(rst), .s(bus));
  sobel_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) u_dut8 (.clk(clk), .rst(rst), .s(bus8));

  int n_cmp = 0;
  int n_bad = 0;
  int mr, mc, exp_fd, got_fd;
  logic [7:0] base;
  bit started = 0;
  exp_t  q[$];
  exp8_t q8[$];
  logic [103:0] snap;
  logic acc_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [103:0] out_vec();
    return {bus.p00, bus.p01, bus.p02, bus.p10, bus.p11, bus.p12,
            bus.p20, bus.p21, bus.p22, bus.win_row, bus.win_col};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sobel_mag();
    int gx, gy, m;
    gx = (int'(bus8.p02) + 2 * int'(bus8.p12) + int'(bus8.p22))
       - (int'(bus8.p00) + 2 * int'(bus8.p10) + int'(bus8.p20));
    gy = (int'(bus8.p20) + 2 * int'(bus8.p21) + int'(bus8.p22))
       - (int'(bus8.p00) + 2 * int'(bus8.p01) + int'(bus8.p02));
    m = iabs(gx) + iabs(gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Model: drive one accepted pixel, predict its window and advance the counters
  task automatic send(input bit s);
    int er, ec;
    exp_t e;
    er = s ? 0 : mr;
    ec = s ? 0 : mc;
    bus.pix_in    = 8'(int'(base) + er * 16 + ec);
    bus.pix_valid = 1'b1;
    bus.sof       = s;
    if (er >= 2 && ec >= 2) begin
      for (int n = 0; n < 3; n++)
        for (int m = 0; m < 3; m++)
          e.win[(8 - (n * 3 + m)) * 8 +: 8] = 8'(int'(base) + (er - 2 + n) * 16 + (ec - 2 + m));
      e.row = 16'(er - 1);
      e.col = 16'(ec - 1);
      e.fd  = !s && er == H - 1 && ec == W - 1;
      if (e.fd) exp_fd++;
      q.push_back(e);
    end
    if (ec == W - 1) begin
      mc = 0;
      mr = (er == H - 1) ? 0 : er + 1;
    end else begin
      mc = ec + 1;
      mr = er;
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.pix_in = 8'($urandom);
      bus.sof    = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.sof = 1'b0;
  endtask

  task automatic frame(input bit first_sof, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      send(first_sof && i == 0);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  always @(posedge clk) acc_q <= bus.pix_valid || rst;

  always @(negedge clk) begin
    if (started) begin
      if (bus.frame_done) got_fd++;
      if (bus.win_valid) begin
        chk("extra_window", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("window", out_vec() >> 32, e.win);
          chk("win_row", bus.win_row, e.row);
          chk("win_col", bus.win_col, e.col);
          chk("frame_done", bus.frame_done, e.fd);
        end
      end else begin
        chk("frame_done_idle", bus.frame_done, 0);
        if (!acc_q) chk("hold", out_vec(), snap);
      end
      snap = out_vec();
    end
  end

  always @(negedge clk) begin
    if (started && bus8.win_valid) begin
      chk("extra_window8", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        exp8_t e8;
        e8 = q8.pop_front();
        chk("sobel_edge", 16'(sobel_mag()), e8.edge_val);
        chk("win_col8", bus8.win_col, e8.col);
      end
    end
  end

  initial begin
    bus.pix_in = 0; bus.pix_valid = 0; bus.sof = 0;
    bus8.pix_in = 0; bus8.pix_valid = 0; bus8.sof = 0;
    mr = 0; mc = 0; exp_fd = 0; got_fd = 0; base = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_vec(), bus.win_valid, bus.frame_done}, 0);
    rst = 1'b0;
    started = 1;

    // continuous frame, then the same frame with random gaps
    frame(1, 0);
    idle(3);
    frame(1, 1);
    idle(3);

    // back-to-back frames, sof only on the first
    frame(1, 0);
    frame(0, 0);
    idle(3);

    // sof lands where (2,3) would have been; new frame uses different data
    base = 8'h40;
    for (int i = 0; i < 2 * W + 3; i++) send(i == 0);
    base = 8'h80;
    send(1);
    for (int i = 1; i < W * H; i++) send(0);
    idle(3);

    // reset right after (3,1), colliding with a valid pixel that must be dropped
    base = 8'h10;
    for (int i = 0; i < 3 * W + 2; i++) send(i == 0);
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in = 8'hff;
    @(posedge clk); #1;
    chk("midframe_reset", {out_vec(), bus.win_valid, bus.frame_done}, 0);
    chk("queue_at_reset", q.size(), 0);
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    mr = 0; mc = 0;
    base = 8'h60;
    frame(0, 0);
    idle(3);

    // 8x8 vertical step image feeding a Sobel magnitude
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        exp8_t e8;
        bus8.pix_in = (c >= 4) ? 8'd200 : 8'd0;
        bus8.pix_valid = 1'b1;
        bus8.sof = (r == 0 && c == 0);
        if (r >= 2 && c >= 2) begin
          e8.edge_val = (c - 1 == 3 || c - 1 == 4) ? 16'd255 : 16'd0;
          e8.col = 16'(c - 1);
          q8.push_back(e8);
        end
        @(posedge clk); #1;
      end
    bus8.pix_valid = 1'b0;
    bus8.sof = 1'b0;
    idle(3);

    chk("leftover_windows", q.size(), 0);
    chk("leftover_windows8", q8.size(), 0);
    chk("frame_done_count", got_fd, exp_fd);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
